// File: rtl/branch_resolve_queue_pkg.sv
// Shared constants for the branch resolve queue, its counters, and the
// predictor/fetch stages that talk to it.
package branch_resolve_queue_pkg;

  localparam int BRQ_DEPTH = 8;
  localparam int BRQ_TAG_W = 3;
  localparam int BRQ_PC_W  = 16;
  localparam int BRQ_CNT_W = 16;

  localparam int ENTRY_PC_W     = BRQ_PC_W;
  localparam int ENTRY_PRED_W   = 1;
  localparam int ENTRY_ACTUAL_W = 1;

endpackage

// File: rtl/branch_resolve_queue_sat_counter.sv
// Saturating up-counter used for the retired-branch and mispredict statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count increments, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-flight branch tracker: allocates in prediction order, accepts resolutions
// in any order, and retires results back to the predictor strictly in order.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH,
  parameter int TAG_W = BRQ_TAG_W,
  parameter int PC_W  = BRQ_PC_W,
  parameter int CNT_W = BRQ_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic [PC_W-1:0]  pred_pc,
  input  logic             pred_taken,
  output logic             pred_ready,
  output logic [TAG_W-1:0] pred_tag,
  input  logic             resolve_valid,
  input  logic [TAG_W-1:0] resolve_tag,
  input  logic             resolve_taken,
  output logic             result_valid,
  output logic [PC_W-1:0]  result_pc,
  output logic             result,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispred_count
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] resolved_q;
  logic [DEPTH-1:0] pred_q;
  logic [DEPTH-1:0] actual_q;
  logic [PC_W-1:0]  pc_q [DEPTH];

  logic [TAG_W-1:0] head_q;
  logic [TAG_W-1:0] tail_q;
  logic [TAG_W:0]   count_q;

  logic alloc;
  logic resolve_hit;
  logic retire;
  logic head_mispredict;

  // Readiness comes only from the registered occupancy, so a full queue stays
  // closed on the edge where its head retires.
  assign pred_ready      = (count_q < (TAG_W+1)'(DEPTH));
  assign pred_tag        = tail_q;
  assign alloc           = pred_valid & pred_ready;
  assign resolve_hit     = resolve_valid & valid_q[resolve_tag] & ~resolved_q[resolve_tag];
  assign retire          = valid_q[head_q] & resolved_q[head_q];
  assign head_mispredict = actual_q[head_q] ^ pred_q[head_q];

  // Per-entry storage: allocate at tail, mark resolutions, clear on retire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      resolved_q <= '0;
      pred_q     <= '0;
      actual_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc && (tail_q == TAG_W'(i))) begin
          valid_q[i]    <= 1'b1;
          resolved_q[i] <= 1'b0;
          pc_q[i]       <= pred_pc;
          pred_q[i]     <= pred_taken;
        end else begin
          if (retire && (head_q == TAG_W'(i))) begin
            valid_q[i] <= 1'b0;
          end
          if (resolve_hit && (resolve_tag == TAG_W'(i))) begin
            resolved_q[i] <= 1'b1;
            actual_q[i]   <= resolve_taken;
          end
        end
      end
    end
  end

  // Ring pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (alloc) begin
        tail_q <= tail_q + TAG_W'(1);
      end
      if (retire) begin
        head_q <= head_q + TAG_W'(1);
      end
      case ({alloc, retire})
        2'b10:   count_q <= count_q + (TAG_W+1)'(1);
        2'b01:   count_q <= count_q - (TAG_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Registered retire result to the predictor; pc/direction hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_valid <= 1'b0;
      result_pc    <= '0;
      result       <= 1'b0;
      mispredict   <= 1'b0;
    end else begin
      result_valid <= retire;
      mispredict   <= retire & head_mispredict;
      if (retire) begin
        result_pc <= pc_q[head_q];
        result    <= actual_q[head_q];
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_branch_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire),
    .count (branch_count)
  );

  sat_counter #(.W(CNT_W)) u_mispred_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire & head_mispredict),
    .count (mispred_count)
  );

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios plus random traffic,
// compared every cycle against an in-order queue model.
module tb_branch_resolve_queue;
  import branch_resolve_queue_pkg::*;

  localparam int DEPTH = BRQ_DEPTH;
  localparam int TAG_W = BRQ_TAG_W;
  localparam int PC_W  = BRQ_PC_W;
  localparam int CNT_W = BRQ_CNT_W;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             pred_valid;
  logic [PC_W-1:0]  pred_pc;
  logic             pred_taken;
  logic             pred_ready;
  logic [TAG_W-1:0] pred_tag;
  logic             resolve_valid;
  logic [TAG_W-1:0] resolve_tag;
  logic             resolve_taken;
  logic             result_valid;
  logic [PC_W-1:0]  result_pc;
  logic             result;
  logic             mispredict;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispred_count;

  int passed = 0;
  int total  = 0;

  // Model: allocation-order list of tags plus per-tag records
  int unsigned order[$];
  bit          m_valid    [DEPTH];
  bit          m_resolved [DEPTH];
  bit          m_pred     [DEPTH];
  bit          m_actual   [DEPTH];
  int unsigned m_pc       [DEPTH];
  int unsigned m_alloc_total;
  bit          e_rv, e_res, e_mis;
  int unsigned e_pc;
  longint      e_bc, e_mc;

  always #5 clk = ~clk;

  branch_resolve_queue dut (
    .clk           (clk),
    .rst           (rst),
    .pred_valid    (pred_valid),
    .pred_pc       (pred_pc),
    .pred_taken    (pred_taken),
    .pred_ready    (pred_ready),
    .pred_tag      (pred_tag),
    .resolve_valid (resolve_valid),
    .resolve_tag   (resolve_tag),
    .resolve_taken (resolve_taken),
    .result_valid  (result_valid),
    .result_pc     (result_pc),
    .result        (result),
    .mispredict    (mispredict),
    .branch_count  (branch_count),
    .mispred_count (mispred_count)
  );

  function automatic void modelReset();
    order.delete();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0; m_resolved[i] = 0; m_pred[i] = 0; m_actual[i] = 0; m_pc[i] = 0;
    end
    m_alloc_total = 0;
    e_rv = 0; e_res = 0; e_mis = 0; e_pc = 0; e_bc = 0; e_mc = 0;
  endfunction

  function automatic void modelStep(bit pv, int unsigned ppc, bit pt, bit rv, int unsigned rtag, bit rtk);
    bit do_retire  = (order.size() > 0) && m_resolved[order[0]];
    bit do_alloc   = pv && (order.size() < DEPTH);
    bit do_resolve = rv && m_valid[rtag] && !m_resolved[rtag];
    int unsigned new_tag = m_alloc_total % DEPTH;
    int unsigned h;
    if (do_retire) begin
      h = order.pop_front();
      e_rv = 1; e_pc = m_pc[h]; e_res = m_actual[h]; e_mis = (m_actual[h] != m_pred[h]);
      m_valid[h] = 0;
      if (e_bc < CNT_MAX) e_bc++;
      if (e_mis && e_mc < CNT_MAX) e_mc++;
    end else begin
      e_rv = 0; e_mis = 0;
    end
    if (do_resolve) begin
      m_resolved[rtag] = 1; m_actual[rtag] = rtk;
    end
    if (do_alloc) begin
      m_valid[new_tag] = 1; m_resolved[new_tag] = 0;
      m_pc[new_tag] = ppc; m_pred[new_tag] = pt;
      order.push_back(new_tag);
      m_alloc_total++;
    end
  endfunction

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic checkOutput();
    checkValue("pred_ready",    32'(pred_ready),    32'(order.size() < DEPTH));
    checkValue("pred_tag",      32'(pred_tag),      m_alloc_total % DEPTH);
    checkValue("result_valid",  32'(result_valid),  32'(e_rv));
    checkValue("result_pc",     32'(result_pc),     e_pc);
    checkValue("result",        32'(result),        32'(e_res));
    checkValue("mispredict",    32'(mispredict),    32'(e_mis));
    checkValue("branch_count",  32'(branch_count),  32'(e_bc));
    checkValue("mispred_count", 32'(mispred_count), 32'(e_mc));
  endtask

  task automatic applyStimulus(input bit pv, input int unsigned ppc, input bit pt,
                               input bit rv, input int unsigned rtag, input bit rtk);
    pred_valid    = pv;
    pred_pc       = PC_W'(ppc);
    pred_taken    = pt;
    resolve_valid = rv;
    resolve_tag   = TAG_W'(rtag);
    resolve_taken = rtk;
    modelStep(pv, ppc, pt, rv, rtag, rtk);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    pred_valid = 0; pred_pc = '0; pred_taken = 0;
    resolve_valid = 0; resolve_tag = '0; resolve_taken = 0;
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;
  endtask

  initial begin
    int unsigned t_a, t_b, t_u;
    int unsigned perm[$];
    int unsigned tmp;
    int j;
    bit rv;
    int unsigned rtag;

    // Test 1: reset
    doReset();
    checkValue("rst_ready", 32'(pred_ready), 1);
    checkValue("rst_tag", 32'(pred_tag), 0);
    checkValue("rst_rv", 32'(result_valid), 0);
    checkValue("rst_bc", 32'(branch_count), 0);

    // Test 2: single branch, correct prediction
    applyStimulus(1, 'h0010, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 1);
    checkValue("t2_no_early_rv", 32'(result_valid), 0);
    idle();
    checkValue("t2_rv", 32'(result_valid), 1);
    checkValue("t2_pc", 32'(result_pc), 'h0010);
    checkValue("t2_res", 32'(result), 1);
    checkValue("t2_mis", 32'(mispredict), 0);
    checkValue("t2_bc", 32'(branch_count), 1);
    idle();
    checkValue("t2_pulse_end", 32'(result_valid), 0);

    // Test 3: out-of-order resolution, in-order retire
    t_a = m_alloc_total % DEPTH;
    applyStimulus(1, 'h0020, 0, 0, 0, 0);
    t_b = m_alloc_total % DEPTH;
    applyStimulus(1, 'h0024, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, t_b, 1);
    idle();
    idle();
    checkValue("t3_blocked", 32'(result_valid), 0);
    applyStimulus(0, 0, 0, 1, t_a, 0);
    idle();
    checkValue("t3_a_rv", 32'(result_valid), 1);
    checkValue("t3_a_pc", 32'(result_pc), 'h0020);
    idle();
    checkValue("t3_b_rv", 32'(result_valid), 1);
    checkValue("t3_b_pc", 32'(result_pc), 'h0024);
    idle();
    checkValue("t3_done", 32'(result_valid), 0);

    // Test 4: fill, overflow drop, wrap
    doReset();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 'h0100 + 4*i, i[0], 0, 0, 0);
    checkValue("t4_full_ready", 32'(pred_ready), 0);
    checkValue("t4_wrap_tag", 32'(pred_tag), 0);
    applyStimulus(1, 'h01ff, 1, 0, 0, 0);
    checkValue("t4_drop_ready", 32'(pred_ready), 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkValue("t4_still_full", 32'(pred_ready), 0);
    applyStimulus(1, 'h01ee, 1, 0, 0, 0);
    checkValue("t4_retire_rv", 32'(result_valid), 1);
    checkValue("t4_retire_pc", 32'(result_pc), 'h0100);
    checkValue("t4_ready_back", 32'(pred_ready), 1);
    checkValue("t4_tag_back", 32'(pred_tag), 0);
    for (int i = 1; i < DEPTH; i++) perm.push_back(i);
    for (int i = perm.size() - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    foreach (perm[k]) applyStimulus(0, 0, 0, 1, perm[k], perm[k] % 2);
    for (int i = 0; i < 4 * DEPTH && order.size() > 0; i++) idle();
    idle();
    checkValue("t4_bc", 32'(branch_count), 8);
    checkValue("t4_mc", 32'(mispred_count), 0);

    // Test 5: mispredict and duplicate resolves
    t_a = m_alloc_total % DEPTH;
    applyStimulus(1, 'h0030, 1, 0, 0, 0);
    t_u = m_alloc_total % DEPTH;
    applyStimulus(1, 'h0034, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, t_u, 1);
    applyStimulus(0, 0, 0, 1, t_u, 0);
    applyStimulus(0, 0, 0, 1, t_a, 0);
    idle();
    checkValue("t5_rv", 32'(result_valid), 1);
    checkValue("t5_pc", 32'(result_pc), 'h0030);
    checkValue("t5_res", 32'(result), 0);
    checkValue("t5_mis", 32'(mispredict), 1);
    checkValue("t5_mc", 32'(mispred_count), 1);
    idle();
    checkValue("t5_dup_res", 32'(result), 1);
    checkValue("t5_dup_mis", 32'(mispredict), 0);
    applyStimulus(0, 0, 0, 1, t_a, 1);
    idle();
    checkValue("t5_no_extra", 32'(result_valid), 0);
    checkValue("t5_bc", 32'(branch_count), 10);

    // Test 6: asynchronous reset mid-cycle with entries pending
    t_a = m_alloc_total % DEPTH;
    applyStimulus(1, 'h0040, 0, 0, 0, 0);
    applyStimulus(1, 'h0044, 0, 0, 0, 0);
    applyStimulus(1, 'h0048, 0, 1, t_a, 0);
    idle();
    checkValue("t6_pre_rv", 32'(result_valid), 1);
    #3;
    rst = 1'b1;
    #1;
    checkValue("t6_async_rv", 32'(result_valid), 0);
    checkValue("t6_async_pc", 32'(result_pc), 0);
    checkValue("t6_async_bc", 32'(branch_count), 0);
    checkValue("t6_async_tag", 32'(pred_tag), 0);
    checkValue("t6_async_ready", 32'(pred_ready), 1);
    doReset();
    applyStimulus(1, 'h0050, 1, 0, 0, 0);
    checkValue("t6_first_tag_next", 32'(pred_tag), 1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rv = ($urandom_range(0, 99) < 50);
      if (order.size() > 0 && $urandom_range(0, 99) < 70)
        rtag = order[$urandom_range(0, order.size() - 1)];
      else
        rtag = $urandom_range(0, DEPTH - 1);
      applyStimulus($urandom_range(0, 99) < 55, $urandom_range(0, 16'hffff), $urandom_range(0, 1),
                    rv, rtag, $urandom_range(0, 1));
    end
    for (int c = 0; c < 200 && order.size() > 0; c++) begin
      applyStimulus(0, 0, 0, 1, order[$urandom_range(0, order.size() - 1)], $urandom_range(0, 1));
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
